// File: rtl/im_loader.sv
// im_loader -- boot-time instruction-memory loader.
//
// This module accepts a framed byte stream and writes the payload into a
// DEPTH-byte instruction memory, one byte per cycle. The CPU is held in
// reset until a complete, valid image is in place.
//
// Frame layout: LEN_HI, LEN_LO, payload[0..len-1], optional checksum byte.
//
// Optional feature (macro IM_LOADER_CSUM_EN):
//   When defined, a trailing checksum byte must equal the XOR of all
//   payload bytes, otherwise the frame ends in ERR.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start               begin a load (honoured in IDLE, DONE, ERR)
//   in_valid, in_data   stream byte offered by the source
//   in_ready            loader accepts a byte this cycle
//   im_we/addr/wdata    registered IM byte write port
//   cpu_hold            1 keeps the CPU in reset
//   done, err           image accepted / frame rejected
//   load_cnt            payload bytes written in the current/last load
//
// Handshake: a byte moves on any cycle where in_valid && in_ready. The source
// holds in_data stable while in_valid is high and in_ready is low. in_ready
// depends only on state, never on in_valid.
module im_loader #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [7:0]    im_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [AW:0]   load_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR
`ifdef IM_LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [AW:0]   load_cnt_q, load_cnt_d;
  logic          im_we_q, im_we_d;
  logic [AW-1:0] im_addr_q, im_addr_d;
  logic [7:0]    im_wdata_q, im_wdata_d;
`ifdef IM_LOADER_CSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic          xfer;
  logic          go_start;
  logic [15:0]   len_full;
  logic          len_bad;
  logic [AW:0]   cnt_plus;
  logic          last_byte;

  assign xfer     = in_valid && in_ready;
  assign go_start = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  // Full length as it will be once the LEN_LO byte is latched.
  assign len_full = {len_q[15:8], in_data};
  assign len_bad  = (len_full == 16'd0) || (len_full > 16'(DEPTH)) || (len_full[1:0] != 2'b00);
  assign cnt_plus = load_cnt_q + 1'b1;
  assign last_byte = ({{(15-AW){1'b0}}, cnt_plus} == len_q);

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      load_cnt_q <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
`ifdef IM_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      load_cnt_q <= load_cnt_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
`ifdef IM_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: if (xfer) state_d = len_bad ? S_ERR : S_DATA;
      S_DATA: begin
        if (xfer && last_byte) begin
`ifdef IM_LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IM_LOADER_CSUM_EN
      S_CSUM:   if (xfer) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
`endif
      S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: length capture, byte counter, registered IM write port
  always_comb begin
    len_d      = len_q;
    load_cnt_d = load_cnt_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
`ifdef IM_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif
    if (go_start) begin
      len_d      = '0;
      load_cnt_d = '0;
`ifdef IM_LOADER_CSUM_EN
      csum_d     = '0;
`endif
    end
    if (xfer && state_q == S_LEN_HI) len_d[15:8] = in_data;
    if (xfer && state_q == S_LEN_LO) len_d[7:0]  = in_data;
    if (xfer && state_q == S_DATA) begin
      // Length <= DEPTH keeps the low AW bits in range; no wrap possible.
      im_we_d    = 1'b1;
      im_addr_d  = load_cnt_q[AW-1:0];
      im_wdata_d = in_data;
      load_cnt_d = cnt_plus;
`ifdef IM_LOADER_CSUM_EN
      csum_d     = csum_q ^ in_data;
`endif
    end
  end

  // Output logic
  always_comb begin
    in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA)
`ifdef IM_LOADER_CSUM_EN
               || (state_q == S_CSUM)
`endif
               ;
    cpu_hold = (state_q != S_DONE);
    done     = (state_q == S_DONE);
    err      = (state_q == S_ERR);
    im_we    = im_we_q;
    im_addr  = im_addr_q;
    im_wdata = im_wdata_q;
    load_cnt = load_cnt_q;
  end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time instruction-memory loader for the pipelined core. Accepts a framed byte stream (length header, payload, optional checksum) over a valid/ready handshake and writes it byte-by-byte into the 512-byte instruction memory through a byte write port, instruction MSB at the lowest byte address to match IM fetch order. Holds the CPU in reset until a complete, valid image is in place.

## Interface
- `DEPTH`, 512, IM size in bytes; maximum accepted payload length
- `AW`, 9, IM byte-address width; `2**AW == DEPTH`
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a load; honoured in IDLE, DONE, ERR; ignored otherwise
- `in_valid`  in  1  stream byte valid
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader can accept a byte this cycle
- `im_we`  out  1  IM byte write strobe, one cycle per byte
- `im_addr`  out  AW  IM byte address
- `im_wdata`  out  8  IM byte data
- `cpu_hold`  out  1  1 = keep CPU in reset (drive core `rstn` low)
- `done`  out  1  image loaded and accepted
- `err`  out  1  frame rejected
- `load_cnt`  out  AW+1  payload bytes written in current/last load

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM (only with macro), DONE, ERR.
- Transfer occurs on a cycle with `in_valid && in_ready`; `in_ready` = 1 exactly in LEN_HI, LEN_LO, DATA, CSUM. No transfer in other states regardless of `in_valid`.
- IDLE --start--> LEN_HI; clears `load_cnt`, length, checksum accumulator.
- LEN_HI: transfer latches length[15:8] -> LEN_LO. LEN_LO: latches length[7:0], then checks the 16-bit length: 0, > DEPTH, or not a multiple of 4 -> ERR; else -> DATA.
- DATA: each transfer writes `in_data` to address `load_cnt[AW-1:0]`, increments `load_cnt`. After the transfer making `load_cnt == length`: -> CSUM if enabled, else DONE.
- DONE / ERR: hold; `start` re-enters LEN_HI (reload). IM contents beyond a new image's length are not cleared.
- `cpu_hold` = 1 in every state except DONE; `done` = (state == DONE); `err` = (state == ERR).
- Length header bytes and checksum byte are never written to IM.

## Timing
- Reset: state IDLE; `in_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0, `load_cnt`=0.
- Write latency 1: byte transferred in cycle N appears as `im_we`=1, `im_addr`, `im_wdata` in cycle N+1 (registered); `im_we` is 0 in cycles without a preceding DATA transfer. `im_addr`/`im_wdata` hold last value when `im_we`=0.
- Full-rate: one byte per cycle sustained with `in_valid` held high.
- Last DATA byte in cycle N: state DONE (no macro) from N+1, `done`/`cpu_hold` change at N+1 alongside the final `im_we`; IM write completes the same edge the CPU is released.
- `start` asserted with a stream byte in IDLE: only the state change happens; the byte is not consumed (`in_ready`=0 in IDLE).
- `rst` mid-load: immediate return to IDLE at next edge; pending `im_we` dropped; bytes already written stay in IM.
- Address never wraps: length ≤ DEPTH guarantees `load_cnt[AW-1:0]` ≤ DEPTH-1 when writing.

## Configuration
- `IM_LOADER_CSUM_EN` defined: after the last payload byte, state CSUM accepts one byte; if it equals the XOR of all payload bytes -> DONE, else -> ERR (IM already written; CPU stays held). Accumulator cleared on entry to LEN_HI.
- Not defined: no CSUM state, no accumulator logic; last payload byte goes directly to DONE.

## Test plan
- Reset then idle: `rst`=1 two cycles -> all outputs at reset values, `cpu_hold`=1, `in_ready`=0 with `in_valid`=1.
- Basic load, no macro: start, stream 00 08 | 3C 01 00 10 20 21 00 04 at full rate -> eight `im_we` pulses, addresses 0..7 with those bytes in order, `done`=1 and `cpu_hold`=0 one cycle after last byte, `load_cnt`=8.
- Bad length: headers 00 00, 00 06, 02 04 -> ERR after LEN_LO byte each time, no `im_we`, `cpu_hold`=1; `start` from ERR restarts cleanly.
- Backpressure/gaps: same 8-byte image with `in_valid` toggling 1/0 randomly -> identical writes, each exactly once.
- Checksum (macro defined): payload 12 34 56 78, csum 08 -> DONE; csum 09 -> ERR, `done`=0.
- Reset mid-load: `rst` after 3 payload bytes -> IDLE next edge, no further `im_we`, `load_cnt`=0; subsequent full load succeeds.
